divider16x8: RTL and testbench
==============================

# divider16x8

Sequential restoring divider: computes quotient and remainder of a 16-bit unsigned dividend by an 8-bit unsigned divisor, one quotient bit per clock. It is the inverse companion of the 8x8 shift-add multiplier in the CSLab #2 datapath. It shares that block's bit-serial style and reuses the existing 8-bit ripple adder as its ALU. A start/busy/done handshake lets an enclosing FSM or testbench launch operations and poll for completion.

## Interface
- No parameters; widths fixed at 16-bit dividend/quotient, 8-bit divisor/remainder.
- clk  input  1  system clock; all state changes on posedge.
- areset  input  1  reset, synchronous, active-high.
- start  input  1  launch request; sampled only in IDLE.
- dividend  input  16  unsigned dividend; captured on the accepting edge.
- divisor  input  8  unsigned divisor; captured on the accepting edge.
- quotient  output  16  result quotient; valid while done=1, held until next accepted start.
- remainder  output  8  result remainder; same validity as quotient.
- busy  output  1  high in EXEC and DONE (state != IDLE).
- done  output  1  high for exactly one cycle (DONE state).
- div_by_zero  output  1  set with done when divisor was 0; held with results.

## Operation
- States: IDLE, EXEC, DONE (2-bit encoding IDLE=0, EXEC=1, DONE=2; 3 unused, decodes to IDLE).
- IDLE, start=1:
  - Q <= dividend, D <= divisor, R <= 9'b0, count <= 0, div_by_zero <= 0.
  - If divisor==0: go directly to DONE with Q=16'hFFFF, R=dividend[7:0], div_by_zero=1.
  - Otherwise go to EXEC.
- IDLE, start=0: hold all registers; outputs keep the last results.
- EXEC iteration, one per edge:
  - R' = {R[7:0], Q[15]} (9 bits).
  - {Cout, S} = Adder8(R'[7:0], ~D, Cin=1).
  - qbit = R'[8] | Cout.
  - R <= qbit ? {1'b0, S} : R'.
  - Q <= {Q[14:0], qbit}.
  - count <= count+1.
  - count==15 on this edge -> DONE.
- Invariant: R < D before every iteration, so R' <= 2D-1 fits 9 bits and R[8] is always 0 after update.
- DONE: done=1; next edge -> IDLE unconditionally. A start seen during DONE is ignored.
- quotient = Q, remainder = R[7:0]; continuously driven from the registers.
- start while busy: ignored, no effect on the operation in progress or its operands.
- dividend/divisor may change freely after the accepting edge.

## Timing
- Reset (areset=1 at posedge): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, count=0. Reset has priority over everything and aborts an operation in progress with no done pulse.
- Normal latency: start accepted at edge t0; iterations at edges t0+1..t0+16; done=1 in the cycle after edge t0+16; IDLE after edge t0+17. Throughput: one division per 18 cycles if start is held high.
- Divide by zero: done=1 in the cycle after edge t0; busy high for that one cycle only.
- busy rises in the cycle after the accepting edge and falls together with done.

## Structure
- Shared package/include file holds the state constants IDLE/EXEC/DONE and the 2-bit state width.
- Single sub-module: the existing Adder8, instantiated once as the subtractor (B = ~divisor, Cin=1). Cout=1 means no borrow.
- Control is inline with a 5-bit iteration counter. No separate FSM module is needed.

## Test plan
- dividend=1000 (16'h03E8), divisor=7 -> quotient=142, remainder=6, div_by_zero=0; done exactly 16 cycles after start edge.
- dividend=16'hFFFF, divisor=255 -> quotient=257, remainder=0. dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0.
- dividend=100, divisor=200 -> quotient=0, remainder=100. dividend=0, divisor=5 -> quotient=0, remainder=0.
- dividend=16'h1234, divisor=0 -> quotient=16'hFFFF, remainder=8'h34, div_by_zero=1; done one cycle after start edge.
- Start 1000/7, then at cycle 5 pulse start with 50/5 and change inputs -> result still 142 r 6. A start after done returns to IDLE yields 10 r 0.
- Start 1000/7, then assert areset at iteration 8 -> all outputs 0 next cycle, no done pulse. A subsequent start 255/16 -> quotient 15, remainder 15.

Source files
------------

// File: rtl/divider16x8_pkg.sv
// Shared constants for the 16/8 restoring divider: control state encoding,
// widths and the last iteration index.
package divider16x8_pkg;

   localparam int STATE_W    = 2;
   localparam int DVD_W      = 16;
   localparam int DVS_W      = 8;
   localparam int CNT_W      = 5;
   localparam logic [CNT_W-1:0] CNT_LAST = 5'd15;

   // Encoding 3 is unused; the controller treats it exactly like IDLE.
   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/divider16x8_adder8.sv
// 8-bit ripple-carry adder; the divider uses it as a subtractor (b = ~divisor, cin = 1).
module divider16x8_adder8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [8:0] carry;

   assign carry[0] = cin;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
         assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign cout = carry[8];

endmodule

// File: rtl/divider16x8.sv
// Bit-serial restoring divider: 16-bit dividend / 8-bit divisor, one quotient
// bit per clock, with a start/busy/done handshake.
module divider16x8
   import divider16x8_pkg::*;
(
   input  logic        clk,
   input  logic        areset,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic [15:0] quotient,
   output logic [7:0]  remainder,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero
);

   state_t           state_reg, state_next;
   logic [15:0]      q_reg, q_next;
   logic [7:0]       d_reg, d_next;
   // The partial remainder's ninth bit is always zero after an update, so
   // only the low byte is kept; the shifted-in top bit lives in r_shift.
   logic [7:0]       r_reg, r_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             dbz_reg, dbz_next;

   logic [8:0]       r_shift;
   logic [7:0]       diff;
   logic             no_borrow;
   logic             qbit;

   assign r_shift = {r_reg, q_reg[15]};

   divider16x8_adder8 u_sub (
      .a    (r_shift[7:0]),
      .b    (~d_reg),
      .cin  (1'b1),
      .sum  (diff),
      .cout (no_borrow)
   );

   // A set ninth bit means R' >= 256 > D, so the subtraction always fits.
   assign qbit = r_shift[8] | no_borrow;

   always_comb begin
      state_next = state_reg;
      q_next     = q_reg;
      d_next     = d_reg;
      r_next     = r_reg;
      count_next = count_reg;
      dbz_next   = dbz_reg;
      case (state_reg)
         EXEC: begin
            q_next     = {q_reg[14:0], qbit};
            r_next     = qbit ? diff : r_shift[7:0];
            count_next = count_reg + 5'd1;
            if (count_reg == CNT_LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            if (start) begin
               q_next     = dividend;
               d_next     = divisor;
               r_next     = 8'd0;
               count_next = '0;
               dbz_next   = 1'b0;
               if (divisor == 8'd0) begin
                  q_next     = 16'hFFFF;
                  r_next     = dividend[7:0];
                  dbz_next   = 1'b1;
                  state_next = DONE;
               end else begin
                  state_next = EXEC;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         state_reg <= IDLE;
         q_reg     <= '0;
         d_reg     <= '0;
         r_reg     <= '0;
         count_reg <= '0;
         dbz_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         q_reg     <= q_next;
         d_reg     <= d_next;
         r_reg     <= r_next;
         count_reg <= count_next;
         dbz_reg   <= dbz_next;
      end
   end

   assign quotient    = q_reg;
   assign remainder   = r_reg;
   assign busy        = (state_reg == EXEC) || (state_reg == DONE);
   assign done        = (state_reg == DONE);
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_divider16x8.sv
// Directed self-checking bench for divider16x8 with hand-computed expectations.
module tb_divider16x8;

   logic        clk = 1'b0;
   logic        areset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int total = 0;
   int bad   = 0;

   divider16x8 dut (
      .clk         (clk),
      .areset      (areset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepting edge happens inside; operands are scrambled right after it.
   task automatic start_op(input logic [15:0] dvd, input logic [7:0] dvs);
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = 16'(~dvd);
      divisor  = 8'(~dvs + 8'd3);
   endtask

   task automatic wait_done(output int cyc, output logic ok);
      cyc = 0;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
      ok = done;
   endtask

   task automatic check_result(input string tag, input logic [15:0] eq, input logic [7:0] er,
                               input logic edbz);
      check_val({tag, " quotient"}, 32'(quotient), 32'(eq));
      check_val({tag, " remainder"}, 32'(remainder), 32'(er));
      check_val({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
   endtask

   task automatic run(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                      input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                      input int elat);
      int   cyc;
      logic ok;
      start_op(dvd, dvs);
      check_val({tag, " busy after accept"}, 32'(busy), 32'd1);
      wait_done(cyc, ok);
      check_val({tag, " done seen"}, 32'(ok), 32'd1);
      check_val({tag, " latency"}, 32'(cyc), 32'(elat));
      check_result(tag, eq, er, edbz);
      tick();
      check_val({tag, " done one cycle"}, 32'(done), 32'd0);
      check_val({tag, " busy falls"}, 32'(busy), 32'd0);
      check_val({tag, " quotient held"}, 32'(quotient), 32'(eq));
   endtask

   initial begin
      int   cyc;
      int   pulses;
      logic ok;

      tick();
      tick();
      check_result("reset", 16'd0, 8'd0, 1'b0);
      check_val("reset busy", 32'(busy), 32'd0);
      check_val("reset done", 32'(done), 32'd0);
      areset = 1'b0;
      tick();

      run("1000/7",  16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 16);
      run("FFFF/255", 16'hFFFF, 8'd255, 16'd257,   8'd0,   1'b0, 16);
      run("FFFF/1",  16'hFFFF,  8'd1,   16'hFFFF,  8'd0,   1'b0, 16);
      run("100/200", 16'd100,   8'd200, 16'd0,     8'd100, 1'b0, 16);
      run("0/5",     16'd0,     8'd5,   16'd0,     8'd0,   1'b0, 16);
      run("1234/0",  16'h1234,  8'd0,   16'hFFFF,  8'h34,  1'b1, 0);

      // A start during EXEC must not disturb the running division.
      start_op(16'd1000, 8'd7);
      repeat (4) tick();
      dividend = 16'd50;
      divisor  = 8'd5;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = 16'hABCD;
      divisor  = 8'd0;
      wait_done(cyc, ok);
      check_val("busy-start done seen", 32'(ok), 32'd1);
      check_val("busy-start latency", 32'(cyc + 5), 32'd16);
      check_result("busy-start", 16'd142, 8'd6, 1'b0);
      // A start in the DONE cycle is also ignored.
      dividend = 16'd77;
      divisor  = 8'd3;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      check_val("done-start ignored busy", 32'(busy), 32'd0);
      check_val("done-start quotient held", 32'(quotient), 32'd142);
      tick();
      check_val("done-start still idle", 32'(busy), 32'd0);

      run("50/5", 16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 16);

      // Reset in the middle of EXEC aborts without a done pulse.
      start_op(16'd1000, 8'd7);
      repeat (7) tick();
      check_val("abort mid busy", 32'(busy), 32'd1);
      areset = 1'b1;
      tick();
      check_result("abort", 16'd0, 8'd0, 1'b0);
      check_val("abort busy", 32'(busy), 32'd0);
      check_val("abort done", 32'(done), 32'd0);
      areset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) pulses++;
      end
      check_val("abort no done pulse", 32'(pulses), 32'd0);

      run("255/16", 16'd255, 8'd16, 16'd15, 8'd15, 1'b0, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

endmodule
